// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_key_pkg
// Purpose  : Shared AES-128 key-schedule definitions: round count, 32-bit
//            word type, schedule FSM state encoding and the RCON byte table.
// Revision : 1.0 - initial release
// ============================================================================
package aes_key_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } ks_state_t;

  // Round constant byte for round 1..10. Index 0 is never used by the
  // inverse step (round 0 has no predecessor) and returns 0.
  function automatic logic [7:0] rcon_byte(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_xorkey_words.sv
`default_nettype none
// ============================================================================
// Module   : inv_xorkey_words
// Purpose  : One combinational step of the inverse AES-128 key expansion.
//            Un-chains the word XORs of round key r to recover words 1..3 of
//            round key r-1, exposes RotWord of the recovered last word to the
//            external S-box, and strips the G-function from word 0 using the
//            returned SubWord and the round constant of round r.
// Ports    : key       in  128  round-r key {a0,a1,a2,a3}, a0 in [127:96]
//            sub_word  in  32   SubWord(rot_word) from the external S-box
//            rcon      in  8    RCON[r]
//            prev_key  out 128  round-(r-1) key {b0,b1,b2,b3}
//            rot_word  out 32   RotWord(b3), source for the S-box request
// Revision : 1.0 - initial release
// ============================================================================
module inv_xorkey_words
  import aes_key_pkg::*;
(
  input  logic [127:0] key,
  input  word_t        sub_word,
  input  logic [7:0]   rcon,
  output logic [127:0] prev_key,
  output word_t        rot_word
);

  word_t a0, a1, a2, a3;
  word_t b0, b1, b2, b3;

  assign a0 = key[127:96];
  assign a1 = key[95:64];
  assign a2 = key[63:32];
  assign a3 = key[31:0];

  // Forward step was a_i = b_i ^ a_(i-1); undo it from the top word down.
  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;

  // b3 is available before the S-box lookup, which is what lets the whole
  // step close in a single cycle through the external S-box.
  assign rot_word = {b3[23:0], b3[31:24]};

  assign b0 = a0 ^ sub_word ^ {rcon, 24'h000000};

  assign prev_key = {b0, b1, b2, b3};

endmodule
`default_nettype wire

// File: rtl/inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_sched
// Purpose  : Sequential AES-128 inverse key schedule. Captures the round-NR
//            key and presents round keys NR down to 0, one per accepted
//            handshake, using an external combinational S-box for SubWord.
// Ports    : clk_i        in  1    clock, rising edge
//            rst_n        in  1    asynchronous active-low reset
//            abort_i      in  1    (INV_KEY_ABORT_EN only) abandon the walk
//            start_i      in  1    begin a walk, sampled only in IDLE
//            key_last_i   in  128  round-NR key, captured on accepted start
//            key_ready_i  in  1    consumer accepts current round key
//            sub_word_i   in  32   SubWord(sub_word_o) from external S-box
//            sub_word_o   out 32   RotWord request to the external S-box
//            key_valid_o  out 1    key_round_o/round_o valid
//            key_round_o  out 128  current round key (0 when not valid)
//            round_o      out 4    round index (0 when not valid)
//            busy_o       out 1    walk in progress (EMIT or DONE)
//            done_o       out 1    pulse after round-0 key accepted
// Config   : INV_KEY_ABORT_EN - adds abort_i; abort has priority over
//            key_ready_i and returns to IDLE without a done_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_sched
  import aes_key_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk_i,
  input  logic         rst_n,
`ifdef INV_KEY_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         start_i,
  input  logic [127:0] key_last_i,
  input  logic         key_ready_i,
  input  word_t        sub_word_i,
  output word_t        sub_word_o,
  output logic         key_valid_o,
  output logic [127:0] key_round_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] NR_INIT = 4'(NR);

  ks_state_t    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] prev_key;
  word_t        rot_word;
  logic         abort;

`ifdef INV_KEY_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  inv_xorkey_words u_step (
    .key      (key_q),
    .sub_word (sub_word_i),
    .rcon     (rcon_byte(round_q)),
    .prev_key (prev_key),
    .rot_word (rot_word)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d   = key_last_i;
          round_d = NR_INIT;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (key_ready_i) begin
          if (round_q != 4'd0) begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are gated by state so IDLE/DONE never leak the stale key.
  assign key_valid_o = (state_q == EMIT);
  assign key_round_o = key_valid_o ? key_q   : '0;
  assign round_o     = key_valid_o ? round_q : '0;
  assign sub_word_o  = key_valid_o ? rot_word : '0;
  assign busy_o      = (state_q == EMIT) || (state_q == DONE);
  assign done_o      = (state_q == DONE) && !abort;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_key_sched
// Purpose  : Self-checking bench for inv_key_sched. Round keys are predicted
//            by running the forward AES-128 key expansion from a round-0 key;
//            the external S-box is modelled from GF(2^8) inversion plus the
//            AES affine map.
// Config   : INV_KEY_ABORT_EN - also exercises abort_i.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_key_sched;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_last_i;
  logic         key_ready_i;
  logic [31:0]  sub_word_i;
  logic [31:0]  sub_word_o;
  logic         key_valid_o;
  logic [127:0] key_round_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;
`ifdef INV_KEY_ABORT_EN
  logic         abort_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk [0:10];

  always #5 clk_i = ~clk_i;

  inv_key_sched dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
`ifdef INV_KEY_ABORT_EN
    .abort_i     (abort_i),
`endif
    .start_i     (start_i),
    .key_last_i  (key_last_i),
    .key_ready_i (key_ready_i),
    .sub_word_i  (sub_word_i),
    .sub_word_o  (sub_word_o),
    .key_valid_o (key_valid_o),
    .key_round_o (key_round_o),
    .round_o     (round_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // External S-box, combinational.
  always_comb begin
    sub_word_i = {sbox_tab[sub_word_o[31:24]], sbox_tab[sub_word_o[23:16]],
                  sbox_tab[sub_word_o[15:8]],  sbox_tab[sub_word_o[7:0]]};
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);  // b^254 = b^-1, 0 -> 0
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Forward AES-128 key expansion: rk[r] = round-r key.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {127'b0, key_valid_o}, 128'd0);
    chk({tag, "_key"},   key_round_o,            128'd0);
    chk({tag, "_round"}, {124'b0, round_o},      128'd0);
    chk({tag, "_sub"},   {96'b0, sub_word_o},    128'd0);
    chk({tag, "_busy"},  {127'b0, busy_o},       128'd0);
    chk({tag, "_done"},  {127'b0, done_o},       128'd0);
  endtask

  // Starts a walk from the current IDLE cycle and checks every EMIT cycle
  // against the forward expansion of k0.
  task automatic run_walk(input logic [127:0] k0, input bit rand_rdy,
                          input bit stall5, input bit poke7);
    int  exp_r;
    int  cyc;
    int  stall_left;
    bit  stalled_once;
    bit  fin;
    bit  rdy;
    expand(k0);
    start_i     = 1'b1;
    key_last_i  = rk[10];
    key_ready_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy",  {127'b0, busy_o},      128'd0);
    chk("idle_valid", {127'b0, key_valid_o}, 128'd0);
    @(posedge clk_i); #1;
    start_i      = 1'b0;
    key_last_i   = rand128();
    exp_r        = 10;
    cyc          = 0;
    stall_left   = 0;
    stalled_once = 1'b0;
    fin          = 1'b0;
    while (!fin && cyc < 100) begin
      if (stall5 && exp_r == 5 && !stalled_once) begin
        stall_left   = 3;
        stalled_once = 1'b1;
      end
      rdy = (stall_left > 0) ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      key_ready_i = rdy;
      if (poke7 && exp_r == 7) begin
        start_i    = 1'b1;
        key_last_i = rand128();
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      chk("walk_valid", {127'b0, key_valid_o}, 128'd1);
      chk("walk_round", {124'b0, round_o},     128'(exp_r));
      chk("walk_key",   key_round_o,           rk[exp_r]);
      chk("walk_busy",  {127'b0, busy_o},      128'd1);
      chk("walk_done",  {127'b0, done_o},      128'd0);
      if (exp_r > 0)
        chk("walk_sub", {96'b0, sub_word_o},
            {96'b0, rk[exp_r-1][23:0], rk[exp_r-1][31:24]});
      @(posedge clk_i); #1;
      cyc++;
      if (stall_left > 0) stall_left--;
      if (rdy) begin
        if (exp_r == 0) fin = 1'b1;
        else exp_r--;
      end
    end
    start_i     = 1'b0;
    key_ready_i = 1'b0;
    if (!fin) chk("walk_timeout", 128'd0, 128'd1);
    @(negedge clk_i);
    chk("end_done",  {127'b0, done_o},      128'd1);
    chk("end_busy",  {127'b0, busy_o},      128'd1);
    chk("end_valid", {127'b0, key_valid_o}, 128'd0);
    chk("end_key",   key_round_o,           128'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    rst_n       = 1'b0;
    start_i     = 1'b0;
    key_last_i  = '0;
    key_ready_i = 1'b0;
`ifdef INV_KEY_ABORT_EN
    abort_i     = 1'b0;
`endif
    start_i     = 1'b1;  // must be ignored during reset
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("reset");
    start_i = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk_i); #1;

    // FIPS-197 A.1 directed walk.
    start_i     = 1'b1;
    key_last_i  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("fips_r10_round", {124'b0, round_o},   128'd10);
    chk("fips_r10_key",   key_round_o,         128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r10_sub",   {96'b0, sub_word_o}, {96'b0, 32'h5c006e57});
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("fips_r9_round", {124'b0, round_o}, 128'd9);
    chk("fips_r9_key",   key_round_o,       128'hac7766f319fadc2128d12941575c006e);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    chk("fips_r0_round", {124'b0, round_o}, 128'd0);
    chk("fips_r0_key",   key_round_o,       128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge clk_i); #1;
    key_ready_i = 1'b0;
    @(negedge clk_i);
    chk("fips_done", {127'b0, done_o}, 128'd1);
    @(posedge clk_i); #1;

    // Back-to-back start in the IDLE re-entry cycle, with backpressure at
    // round 5 and an ignored start at round 7.
    run_walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) run_walk(rand128(), 1'b1, 1'b0, n[0]);

    // Asynchronous reset at round 3.
    expand(rand128());
    start_i     = 1'b1;
    key_last_i  = rk[10];
    key_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_pre_round", {124'b0, round_o}, 128'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk_i); #1;
    chk("rst_hold_done", {127'b0, done_o}, 128'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_after_done", {127'b0, done_o}, 128'd0);
    chk("rst_after_busy", {127'b0, busy_o}, 128'd0);
    run_walk(rand128(), 1'b1, 1'b0, 1'b0);

`ifdef INV_KEY_ABORT_EN
    // Abort at round 6 with ready high.
    expand(rand128());
    start_i     = 1'b1;
    key_last_i  = rk[10];
    key_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("abort_pre_round", {124'b0, round_o}, 128'd6);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i     = 1'b0;
    key_ready_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("abort");
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("abort_no_done", {127'b0, done_o}, 128'd0);
    @(posedge clk_i); #1;
    run_walk(rand128(), 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
